// File: rtl/cim_ctrl_pkg.sv
// Shared types and sizing for the ping-pong CIM controller.
//   loader_state_e : weight loader states (fill standby core / standby full)
//   comp_state_e   : compute sequencer states
//   CIM_*          : geometry and latency constants
package cim_ctrl_pkg;

    localparam int unsigned CIM_ROWS     = 64;
    localparam int unsigned CIM_ROW_AW   = 6;
    localparam int unsigned CIM_STEP_W   = 8;
    localparam int unsigned CIM_PSUM_LAT = 1;
    localparam int unsigned CIM_LAT_W    = $clog2(CIM_PSUM_LAT + 1);
    localparam int unsigned CIM_PERF_W   = 32;

    typedef enum logic {
        L_FILL = 1'b0,
        L_FULL = 1'b1
    } loader_state_e;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_RUN   = 2'd1,
        C_DRAIN = 2'd2
    } comp_state_e;

endpackage

// File: rtl/cim_row_loader.sv
// Weight row loader: streams CIM_ROWS rows into the standby core, then holds
// until the top level swaps cores.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_wt_valid   weight row offered on the weight bus
//   i_swap       cores swap this cycle; standby becomes empty again
//   o_wt_ready   row accepted this cycle (low during and right after reset)
//   o_stdw       standard write strobe (combinational from i_wt_valid)
//   o_std_a      row address for the write
//   o_full       standby core holds a complete weight set
module cim_row_loader
    import cim_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wt_valid,
    input  logic                  i_swap,
    output logic                  o_wt_ready,
    output logic                  o_stdw,
    output logic [CIM_ROW_AW-1:0] o_std_a,
    output logic                  o_full
);

    loader_state_e         r_state;
    loader_state_e         w_state_nxt;
    logic [CIM_ROW_AW-1:0] r_row_cnt;
    logic [CIM_ROW_AW-1:0] w_row_cnt_nxt;
    logic                  r_wt_ready;
    logic                  w_accept;

    assign w_accept = i_wt_valid & r_wt_ready;

    // Next-state: count accepted rows, park in L_FULL after the last one.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_cnt_nxt = r_row_cnt;
        case (r_state)
            L_FILL: begin
                if (w_accept) begin
                    if (r_row_cnt == CIM_ROW_AW'(CIM_ROWS - 1)) begin
                        w_row_cnt_nxt = '0;
                        w_state_nxt   = L_FULL;
                    end else begin
                        w_row_cnt_nxt = r_row_cnt + CIM_ROW_AW'(1);
                    end
                end
            end
            L_FULL: begin
                if (i_swap) begin
                    w_state_nxt = L_FILL;
                end
            end
            default: w_state_nxt = L_FILL;
        endcase
    end

    // State register; ready is held low through reset, then tracks L_FILL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= L_FILL;
            r_row_cnt  <= '0;
            r_wt_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_row_cnt  <= w_row_cnt_nxt;
            r_wt_ready <= (w_state_nxt == L_FILL);
        end
    end

    assign o_wt_ready = r_wt_ready;
    assign o_stdw     = w_accept;
    assign o_std_a    = r_row_cnt;
    assign o_full     = (r_state == L_FULL);

endmodule

// File: rtl/cim_pingpong_ctrl.sv
// Ping-pong scheduler for the two-core CIM unit: loads the standby core while
// the active core computes, swaps cores when safe, and sequences compute jobs.
// Optional feature macro: CIM_PERF_CNT_EN (enables the stall counter).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   wt_valid / wt_ready   weight row handshake; STDW/STD_A drive the unit
//   job_valid / job_ready job handshake; job_steps = CIM cycles (0 -> 1)
//   bank_release          host is done with the active weights
//   CIM_Core_A            active core select
//   CIM_en / slide_en     compute enable and activation window slide
//   STDW / STDR / STD_A   standby write strobe, read (tied 0), row address
//   psum_valid / job_done PSUM valid, last PSUM of a job
//   active_valid          active core holds weights
//   standby_full          standby core holds a complete set
//   perf_stall_cnt        stalled job request cycles (0 without the macro)
module cim_pingpong_ctrl
    import cim_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wt_valid,
    output logic                  wt_ready,
    input  logic                  job_valid,
    input  logic [CIM_STEP_W-1:0] job_steps,
    output logic                  job_ready,
    input  logic                  bank_release,
    output logic                  CIM_Core_A,
    output logic                  CIM_en,
    output logic                  slide_en,
    output logic                  STDW,
    output logic                  STDR,
    output logic [CIM_ROW_AW-1:0] STD_A,
    output logic                  psum_valid,
    output logic                  job_done,
    output logic                  active_valid,
    output logic                  standby_full,
    output logic [CIM_PERF_W-1:0] perf_stall_cnt
);

    comp_state_e             r_cstate;
    comp_state_e             w_cstate_nxt;
    logic [CIM_STEP_W-1:0]   r_step_cnt;
    logic [CIM_STEP_W-1:0]   w_step_nxt;
    logic [CIM_LAT_W-1:0]    r_drain_cnt;
    logic [CIM_LAT_W-1:0]    w_drain_nxt;
    logic                    r_core_a;
    logic                    r_active_valid;
    logic                    r_rel_pend;
    logic                    r_job_ready;
    logic                    r_cim_en;
    logic                    r_slide_en;
    logic                    r_cim_last;
    logic [CIM_PSUM_LAT-1:0] r_psum_sr;
    logic [CIM_PSUM_LAT-1:0] r_last_sr;
    logic                    w_rel_pend_nxt;
    logic                    w_active_nxt;
    logic                    w_job_ready_nxt;
    logic                    w_cim_en_nxt;
    logic                    w_slide_nxt;
    logic                    w_last_nxt;
    logic                    w_std_full;
    logic                    w_swap;
    logic                    w_drained;
    logic                    w_accept_job;

    cim_row_loader u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wt_valid (wt_valid),
        .i_swap     (w_swap),
        .o_wt_ready (wt_ready),
        .o_stdw     (STDW),
        .o_std_a    (STD_A),
        .o_full     (w_std_full)
    );

    // No CIM_en in flight and no PSUM still to come out of the unit.
    assign w_drained    = (r_psum_sr == '0) && !r_cim_en;
    assign w_swap       = w_std_full && (r_cstate == C_IDLE) && w_drained &&
                          (!r_active_valid || r_rel_pend);
    assign w_accept_job = job_valid && r_job_ready;

    // Compute sequencer next-state and next values of the registered outputs.
    always_comb begin
        w_cstate_nxt = r_cstate;
        w_step_nxt   = r_step_cnt;
        w_drain_nxt  = r_drain_cnt;
        case (r_cstate)
            C_IDLE: begin
                if (w_accept_job) begin
                    w_cstate_nxt = C_RUN;
                    w_step_nxt   = (job_steps == '0) ? CIM_STEP_W'(1) : job_steps;
                end
            end
            C_RUN: begin
                w_step_nxt = r_step_cnt - CIM_STEP_W'(1);
                if (r_step_cnt == CIM_STEP_W'(1)) begin
                    w_cstate_nxt = C_DRAIN;
                    w_drain_nxt  = CIM_LAT_W'(CIM_PSUM_LAT);
                end
            end
            C_DRAIN: begin
                w_drain_nxt = r_drain_cnt - CIM_LAT_W'(1);
                if (r_drain_cnt == CIM_LAT_W'(1)) begin
                    w_cstate_nxt = C_IDLE;
                end
            end
            default: w_cstate_nxt = C_IDLE;
        endcase

        w_cim_en_nxt = (w_cstate_nxt == C_RUN);
        // First step of a job is entered from C_IDLE, so no slide on it.
        w_slide_nxt  = w_cim_en_nxt && (r_cstate == C_RUN);
        w_last_nxt   = w_cim_en_nxt && (w_step_nxt == CIM_STEP_W'(1));

        // Release is ignored without valid active weights; swap consumes it.
        w_rel_pend_nxt = r_rel_pend;
        if (w_swap) begin
            w_rel_pend_nxt = 1'b0;
        end else if (bank_release && r_active_valid) begin
            w_rel_pend_nxt = 1'b1;
        end
        w_active_nxt    = r_active_valid | w_swap;
        w_job_ready_nxt = w_active_nxt && (w_cstate_nxt == C_IDLE) && !w_rel_pend_nxt;
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cstate       <= C_IDLE;
            r_step_cnt     <= '0;
            r_drain_cnt    <= '0;
            r_core_a       <= 1'b0;
            r_active_valid <= 1'b0;
            r_rel_pend     <= 1'b0;
            r_job_ready    <= 1'b0;
            r_cim_en       <= 1'b0;
            r_slide_en     <= 1'b0;
            r_cim_last     <= 1'b0;
            r_psum_sr      <= '0;
            r_last_sr      <= '0;
        end else begin
            r_cstate       <= w_cstate_nxt;
            r_step_cnt     <= w_step_nxt;
            r_drain_cnt    <= w_drain_nxt;
            r_core_a       <= r_core_a ^ w_swap;
            r_active_valid <= w_active_nxt;
            r_rel_pend     <= w_rel_pend_nxt;
            r_job_ready    <= w_job_ready_nxt;
            r_cim_en       <= w_cim_en_nxt;
            r_slide_en     <= w_slide_nxt;
            r_cim_last     <= w_last_nxt;
            // PSUM delay line: new sample enters at bit 0, exits at the MSB.
            r_psum_sr      <= CIM_PSUM_LAT'({r_psum_sr, r_cim_en});
            r_last_sr      <= CIM_PSUM_LAT'({r_last_sr, r_cim_last});
        end
    end

`ifdef CIM_PERF_CNT_EN
    logic [CIM_PERF_W-1:0] r_perf_cnt;

    // Saturating count of job requests blocked while weights are present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cnt <= '0;
        end else if (job_valid && !r_job_ready && r_active_valid && (r_perf_cnt != '1)) begin
            r_perf_cnt <= r_perf_cnt + CIM_PERF_W'(1);
        end
    end

    assign perf_stall_cnt = r_perf_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

    assign job_ready    = r_job_ready;
    assign CIM_Core_A   = r_core_a;
    assign CIM_en       = r_cim_en;
    assign slide_en     = r_slide_en;
    assign STDR         = 1'b0;
    assign psum_valid   = r_psum_sr[CIM_PSUM_LAT-1];
    assign job_done     = r_last_sr[CIM_PSUM_LAT-1];
    assign active_valid = r_active_valid;
    assign standby_full = w_std_full;

endmodule
